// File: rtl/target_picker_if.sv
// Handshake bundle between the game controller (master) and the target picker (slave).
interface target_picker_if #(
  parameter int LFSR_W = 8,
  parameter int BOX_W  = 3
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              req;
  logic              busy;
  logic              valid;
  logic [BOX_W-1:0]  box;
  logic [BOX_W-1:0]  last_box;
  logic              fallback;
  logic [LFSR_W-1:0] lfsr_state;

  modport master (
    output seed_load, seed, req,
    input  busy, valid, box, last_box, fallback, lfsr_state
  );

  modport slave (
    input  seed_load, seed, req,
    output busy, valid, box, last_box, fallback, lfsr_state
  );
endinterface

// File: rtl/target_picker.sv
// Pseudo-random box selector: free-running Galois LFSR feeding a rejection-sampling draw FSM.
module target_picker #(
  parameter int                LFSR_W       = 8,
  parameter logic [LFSR_W-1:0] TAPS         = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 8'h01,
  parameter int                NUM_BOXES    = 4,
  parameter int                BOX_W        = 3,
  parameter bit                NO_REPEAT    = 1'b1,
  parameter int                MAX_TRIES    = 8
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  target_picker_if.slave  bus
);

  localparam int CW = (NUM_BOXES <= 2) ? 1 : $clog2(NUM_BOXES);
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [TW-1:0]     tries;
  logic              busy_q;
  logic              valid_q;
  logic              fallback_q;
  logic [BOX_W-1:0]  box_q;
  logic [BOX_W-1:0]  last_q;

  logic [CW-1:0]     cand;
  logic [BOX_W-1:0]  cand_box;
  logic [BOX_W-1:0]  fb_box;
  logic              accept;
  logic              retry;

  // Seed load wins over advance; a zero state (or zero seed) is forced to 1.
  always_comb begin
    lfsr_next = lfsr >> 1;
    if (bus.seed_load)
      lfsr_next = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
    else if (lfsr == '0)
      lfsr_next = LFSR_W'(1);
    else if (lfsr[0])
      lfsr_next = (lfsr >> 1) ^ TAPS;
  end

  assign cand     = lfsr[CW-1:0];
  assign cand_box = BOX_W'(32'(cand) + 32'd1);
  assign accept   = (32'(cand) < 32'(NUM_BOXES)) && !(NO_REPEAT && (cand_box == last_q));
  assign retry    = (32'(tries) + 32'd1) < 32'(MAX_TRIES);
  assign fb_box   = BOX_W'((32'(last_q) % 32'(NUM_BOXES)) + 32'd1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      lfsr       <= SEED_DEFAULT;
      state      <= IDLE;
      tries      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
      box_q      <= '0;
      last_q     <= '0;
    end else begin
      lfsr       <= lfsr_next;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            state  <= DRAW;
            busy_q <= 1'b1;
            tries  <= '0;
          end
        end
        DRAW: begin
          if (accept) begin
            box_q   <= cand_box;
            last_q  <= cand_box;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (retry) begin
            tries <= tries + TW'(1);
          end else begin
            box_q      <= fb_box;
            last_q     <= fb_box;
            valid_q    <= 1'b1;
            fallback_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.fallback   = fallback_q;
  assign bus.box        = box_q;
  assign bus.last_box   = last_q;
  assign bus.lfsr_state = lfsr;

endmodule

// File: tb/tb_target_picker.sv
// Directed bench for target_picker: default config plus two NUM_BOXES=3 variants.
module tb_target_picker;

  logic CLOCK_50;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  target_picker_if #(.LFSR_W(8), .BOX_W(3)) bus_d ();
  target_picker_if #(.LFSR_W(8), .BOX_W(3)) bus_3 ();
  target_picker_if #(.LFSR_W(8), .BOX_W(3)) bus_t ();

  target_picker #(.LFSR_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .NUM_BOXES(4),
                  .BOX_W(3), .NO_REPEAT(1'b1), .MAX_TRIES(8))
    u_dflt (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_d));

  target_picker #(.LFSR_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .NUM_BOXES(3),
                  .BOX_W(3), .NO_REPEAT(1'b0), .MAX_TRIES(8))
    u_nb3 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_3));

  target_picker #(.LFSR_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .NUM_BOXES(3),
                  .BOX_W(3), .NO_REPEAT(1'b0), .MAX_TRIES(2))
    u_nb3t2 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_t));

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request on the default instance and wait a bounded time for valid.
  task automatic draw_dflt(input bit ld, input logic [7:0] s,
                           output int lat, output logic [2:0] b, output logic fb);
    bus_d.seed_load = ld;
    bus_d.seed      = s;
    bus_d.req       = 1'b1;
    tick();
    bus_d.seed_load = 1'b0;
    bus_d.req       = 1'b0;
    lat = 0;
    b   = '0;
    fb  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus_d.valid) begin
        lat = k;
        b   = bus_d.box;
        fb  = bus_d.fallback;
        break;
      end
    end
  endtask

  initial begin
    int          lat, lat3, latt, nvalid, consec, zero_seen, early;
    int          bad_range, bad_rep, bad_lat, bad_last;
    int          cnt [1:4];
    logic [2:0]  b, b3, bt, prev;
    logic        fb, fb3, fbt, prev_valid;
    logic [7:0]  s;

    reset = 1'b1;
    bus_d.seed_load = 1'b0; bus_d.seed = '0; bus_d.req = 1'b0;
    bus_3.seed_load = 1'b0; bus_3.seed = '0; bus_3.req = 1'b0;
    bus_t.seed_load = 1'b0; bus_t.seed = '0; bus_t.req = 1'b0;
    tick();
    tick();
    check("rst_lfsr",     32'(bus_d.lfsr_state), 32'h01);
    check("rst_busy",     32'(bus_d.busy),       32'd0);
    check("rst_valid",    32'(bus_d.valid),      32'd0);
    check("rst_box",      32'(bus_d.box),        32'd0);
    check("rst_last_box", 32'(bus_d.last_box),   32'd0);
    reset = 1'b0;
    tick(); check("free_run_1", 32'(bus_d.lfsr_state), 32'hB8);
    tick(); check("free_run_2", 32'(bus_d.lfsr_state), 32'h5C);
    tick(); check("free_run_3", 32'(bus_d.lfsr_state), 32'h2E);

    // Zero seed maps to 1, then the maximal-length period.
    bus_d.seed_load = 1'b1; bus_d.seed = 8'h00;
    tick();
    bus_d.seed_load = 1'b0;
    check("seed_zero", 32'(bus_d.lfsr_state), 32'h01);
    zero_seen = 0;
    early     = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (bus_d.lfsr_state == 8'h00) zero_seen++;
      if (bus_d.lfsr_state == 8'h01 && i < 255) early++;
    end
    check("period_end",  32'(bus_d.lfsr_state), 32'h01);
    check("period_zero", 32'(zero_seen), 32'd0);
    check("period_early", 32'(early), 32'd0);

    // Seed 01 + req: accepted on the first evaluation.
    bus_d.seed_load = 1'b1; bus_d.seed = 8'h01; bus_d.req = 1'b1;
    tick();
    bus_d.seed_load = 1'b0; bus_d.req = 1'b0;
    check("s01_busy",  32'(bus_d.busy),  32'd1);
    check("s01_valid0", 32'(bus_d.valid), 32'd0);
    tick();
    check("s01_valid",    32'(bus_d.valid),    32'd1);
    check("s01_box",      32'(bus_d.box),      32'd2);
    check("s01_last_box", 32'(bus_d.last_box), 32'd2);
    check("s01_fallback", 32'(bus_d.fallback), 32'd0);
    check("s01_busy_off", 32'(bus_d.busy),     32'd0);
    tick();
    check("s01_valid_pulse", 32'(bus_d.valid), 32'd0);
    check("s01_box_hold",    32'(bus_d.box),   32'd2);

    // Reset in the middle of a draw clears everything without a valid.
    bus_d.req = 1'b1;
    tick();
    bus_d.req = 1'b0;
    check("mid_busy", 32'(bus_d.busy), 32'd1);
    reset = 1'b1;
    #2;
    check("mid_rst_busy",     32'(bus_d.busy),       32'd0);
    check("mid_rst_box",      32'(bus_d.box),        32'd0);
    check("mid_rst_last_box", 32'(bus_d.last_box),   32'd0);
    check("mid_rst_lfsr",     32'(bus_d.lfsr_state), 32'h01);
    #2;
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_d.valid) nvalid++;
    end
    check("mid_rst_no_valid", 32'(nvalid), 32'd0);

    // 5C -> box 1; then B8 rejects twice (repeat, repeat) and 2E gives box 3.
    draw_dflt(1'b1, 8'h5C, lat, b, fb);
    check("s5c_lat", 32'(lat), 32'd1);
    check("s5c_box", 32'(b),   32'd1);
    draw_dflt(1'b1, 8'hB8, lat, b, fb);
    check("sb8_lat", 32'(lat), 32'd3);
    check("sb8_box", 32'(b),   32'd3);
    check("sb8_fb",  32'(fb),  32'd0);

    // NUM_BOXES=3 with seed 17: two out-of-range candidates, then accept or fallback.
    bus_3.seed_load = 1'b1; bus_3.seed = 8'h17; bus_3.req = 1'b1;
    bus_t.seed_load = 1'b1; bus_t.seed = 8'h17; bus_t.req = 1'b1;
    tick();
    bus_3.seed_load = 1'b0; bus_3.req = 1'b0;
    bus_t.seed_load = 1'b0; bus_t.req = 1'b0;
    lat3 = 0; latt = 0; b3 = '0; bt = '0; fb3 = 1'b0; fbt = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus_3.valid && lat3 == 0) begin lat3 = k; b3 = bus_3.box; fb3 = bus_3.fallback; end
      if (bus_t.valid && latt == 0) begin latt = k; bt = bus_t.box; fbt = bus_t.fallback; end
    end
    check("nb3_lat", 32'(lat3), 32'd3);
    check("nb3_box", 32'(b3),   32'd2);
    check("nb3_fb",  32'(fb3),  32'd0);
    check("t2_lat",  32'(latt), 32'd2);
    check("t2_box",  32'(bt),   32'd1);
    check("t2_fb",   32'(fbt),  32'd1);
    check("t2_fb_pulse",  32'(bus_t.fallback), 32'd0);
    check("t2_last_hold", 32'(bus_t.last_box), 32'd1);

    // req pulsed while busy is ignored: exactly one valid.
    draw_dflt(1'b1, 8'h5C, lat, b, fb);
    check("busy_pre_box", 32'(b), 32'd1);
    bus_d.seed_load = 1'b1; bus_d.seed = 8'hB8; bus_d.req = 1'b1;
    tick();
    bus_d.seed_load = 1'b0;
    tick();
    tick();
    bus_d.req = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_d.valid) begin nvalid++; b = bus_d.box; end
    end
    check("busy_req_valids", 32'(nvalid), 32'd1);
    check("busy_req_box",    32'(b),      32'd3);

    // req held high: draws never complete on adjacent cycles.
    bus_d.req  = 1'b1;
    nvalid     = 0;
    consec     = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_d.valid) begin
        nvalid++;
        if (prev_valid) consec++;
      end
      prev_valid = bus_d.valid;
    end
    bus_d.req = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("b2b_consec",   32'(consec),      32'd0);
    check("b2b_progress", 32'(nvalid >= 2), 32'd1);

    // Random seeds: range, no immediate repeat, bounded latency, rough uniformity.
    bad_range = 0; bad_rep = 0; bad_lat = 0; bad_last = 0;
    for (int i = 1; i <= 4; i++) cnt[i] = 0;
    prev = bus_d.last_box;
    for (int i = 0; i < 2000; i++) begin
      s = 8'($urandom);
      draw_dflt(1'b1, s, lat, b, fb);
      if (b < 3'd1 || b > 3'd4) bad_range++;
      else cnt[int'(b)]++;
      if (b == prev) bad_rep++;
      if (lat < 1 || lat > 8) bad_lat++;
      if (bus_d.last_box != b) bad_last++;
      prev = b;
    end
    check("rand_range",    32'(bad_range), 32'd0);
    check("rand_repeat",   32'(bad_rep),   32'd0);
    check("rand_latency",  32'(bad_lat),   32'd0);
    check("rand_last_box", 32'(bad_last),  32'd0);
    for (int i = 1; i <= 4; i++)
      check($sformatf("rand_share_box%0d", i), 32'(cnt[i] >= 300 && cnt[i] <= 700), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
